// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI NOR flash master.
// The DUMMY state is only reachable when the design is built with SPI_DUMMY_EN.
package spi_pkg;

  localparam int SPI_COM_W = 8;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_PAGE_PROG = 8'h02;
  localparam logic [7:0] OP_WREN      = 8'h06;
  localparam logic [7:0] OP_RDSR      = 8'h05;
  localparam logic [7:0] OP_RDID      = 8'h9F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_SS_HOLD
  } spi_state_e;

  // Width of a down-counter that must hold the values 0..n-1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI mode-0 clock generator: sclk low for HALF clk cycles, then high for HALF.
// Held low and re-armed while en is low, so every enabled run starts with a low half.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int HALF = CLK_DIV / 2;
  localparam int DW   = cnt_w(HALF);

  logic [DW-1:0] div_cnt;
  logic          tc;

  assign tc   = (div_cnt == '0);
  // Strobes flag the clk edge on which sclk is about to change.
  assign rise = en && tc && !sclk;
  assign fall = en && tc && sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= DW'(HALF - 1);
      sclk    <= 1'b0;
    end else if (!en) begin
      div_cnt <= DW'(HALF - 1);
      sclk    <= 1'b0;
    end else if (tc) begin
      div_cnt <= DW'(HALF - 1);
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/spi_flash_master.sv
// Framed SPI mode-0 master for serial NOR flash: command, address, dummy, data phases.
// Build with SPI_DUMMY_EN to add the dummy_cycles input and the DUMMY phase.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | tready high, waiting for validflag
// ST_CMD     | shifting out the 8-bit opcode
// ST_ADDR    | shifting out ADDR_W address bits
// ST_DUMMY   | dummy_cycles sclk pulses, mosi low (SPI_DUMMY_EN only)
// ST_DATA    | writing or reading 8*nbytes bits
// ST_SS_HOLD | HALF-cycle tail with sclk low, then ss high for CLK_DIV
module spi_flash_master
  import spi_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 24,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              validflag,
  output logic              tready,
  input  logic [7:0]        command,
  input  logic [ADDR_W-1:0] address,
  input  logic              addr_en,
  input  logic              rd,
  input  logic [2:0]        nbytes,
  input  logic [DATA_W-1:0] data_in,
`ifdef SPI_DUMMY_EN
  input  logic [3:0]        dummy_cycles,
`endif
  output logic [DATA_W-1:0] data_out,
  output logic              validflag_out,
  output logic              sclk,
  output logic              ss,
  output logic              mosi,
  input  logic              miso
);

  localparam int HALF   = CLK_DIV / 2;
  localparam int NB_MAX = DATA_W / 8;
  localparam int SH_W   = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int BC_W   = cnt_w(SH_W);
  localparam int TW     = cnt_w(HALF + CLK_DIV);

  spi_state_e        state;
  spi_state_e        next_phase;
  logic [ADDR_W-1:0] address_q;
  logic [DATA_W-1:0] data_q;
  logic              addr_en_q;
  logic              rd_q;
  logic [2:0]        nb_q;
  logic [2:0]        nb_sat;
  logic [SH_W-1:0]   sh;
  logic [SH_W-1:0]   addr_load;
  logic [SH_W-1:0]   data_load;
  logic [DATA_W-1:0] rx;
  logic [BC_W-1:0]   bit_cnt;
  logic [TW-1:0]     tmr;
  logic              sclk_en;
  logic              sclk_rise;
  logic              sclk_fall;
  logic              drive;

`ifdef SPI_DUMMY_EN
  logic [3:0]        dummy_q;
  logic              dummy_nz;
  assign dummy_nz = (dummy_q != 4'd0);
`endif

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (sclk_en),
    .sclk  (sclk),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  assign nb_sat    = (nbytes > 3'(NB_MAX)) ? 3'(NB_MAX) : nbytes;
  // Phase payloads are left-aligned so mosi always comes from the shifter MSB.
  assign addr_load = SH_W'(address_q) << (SH_W - ADDR_W);
  assign data_load = SH_W'(data_q) << (SH_W - 8 * int'(nb_q));
  assign drive     = (state == ST_CMD) || (state == ST_ADDR) || ((state == ST_DATA) && !rd_q);

  always_comb begin
    next_phase = ST_SS_HOLD;
    case (state)
      ST_CMD: begin
        if (addr_en_q)
          next_phase = ST_ADDR;
`ifdef SPI_DUMMY_EN
        else if (dummy_nz)
          next_phase = ST_DUMMY;
`endif
        else if (nb_q != 3'd0)
          next_phase = ST_DATA;
      end
      ST_ADDR: begin
`ifdef SPI_DUMMY_EN
        if (dummy_nz)
          next_phase = ST_DUMMY;
        else
`endif
        if (nb_q != 3'd0)
          next_phase = ST_DATA;
      end
`ifdef SPI_DUMMY_EN
      ST_DUMMY: begin
        if (nb_q != 3'd0)
          next_phase = ST_DATA;
      end
`endif
      default: next_phase = ST_SS_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      tready        <= 1'b1;
      ss            <= 1'b1;
      mosi          <= 1'b0;
      data_out      <= '0;
      validflag_out <= 1'b0;
      sclk_en       <= 1'b0;
      address_q     <= '0;
      data_q        <= '0;
      addr_en_q     <= 1'b0;
      rd_q          <= 1'b0;
      nb_q          <= '0;
      sh            <= '0;
      rx            <= '0;
      bit_cnt       <= '0;
      tmr           <= '0;
`ifdef SPI_DUMMY_EN
      dummy_q       <= '0;
`endif
    end else begin
      validflag_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (validflag) begin
            address_q <= address;
            data_q    <= data_in;
            addr_en_q <= addr_en;
            rd_q      <= rd;
            nb_q      <= nb_sat;
`ifdef SPI_DUMMY_EN
            dummy_q   <= dummy_cycles;
`endif
            sh        <= SH_W'(command) << (SH_W - SPI_COM_W);
            bit_cnt   <= BC_W'(SPI_COM_W - 1);
            mosi      <= command[7];
            rx        <= '0;
            ss        <= 1'b0;
            tready    <= 1'b0;
            sclk_en   <= 1'b1;
            state     <= ST_CMD;
          end
        end

        ST_SS_HOLD: begin
          // tmr == CLK_DIV lands HALF cycles after the last sclk fall.
          if (tmr == TW'(CLK_DIV)) begin
            ss            <= 1'b1;
            validflag_out <= 1'b1;
            if (rd_q)
              data_out <= rx;
          end
          if (tmr == '0) begin
            state  <= ST_IDLE;
            tready <= 1'b1;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        default: begin
          if (sclk_rise && (state == ST_DATA) && rd_q)
            rx <= {rx[DATA_W-2:0], miso};
          if (sclk_fall) begin
            if (bit_cnt != '0) begin
              bit_cnt <= bit_cnt - 1'b1;
              sh      <= sh << 1;
              mosi    <= drive && sh[SH_W-2];
            end else begin
              state <= next_phase;
              case (next_phase)
                ST_ADDR: begin
                  sh      <= addr_load;
                  bit_cnt <= BC_W'(ADDR_W - 1);
                  mosi    <= addr_load[SH_W-1];
                end
`ifdef SPI_DUMMY_EN
                ST_DUMMY: begin
                  bit_cnt <= BC_W'(int'(dummy_q) - 1);
                  mosi    <= 1'b0;
                end
`endif
                ST_DATA: begin
                  sh      <= data_load;
                  bit_cnt <= BC_W'(8 * int'(nb_q) - 1);
                  mosi    <= !rd_q && data_load[SH_W-1];
                end
                default: begin
                  sclk_en <= 1'b0;
                  mosi    <= 1'b0;
                  tmr     <= TW'(HALF + CLK_DIV - 1);
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_master.sv
// Directed bench for spi_flash_master with a behavioural mode-0 flash model.
// The FAST_READ dummy-cycle step runs only when built with SPI_DUMMY_EN.
module tb_spi_flash_master;
  import spi_pkg::*;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 24;
  localparam int CLK_DIV = 4;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              validflag = 1'b0;
  logic              addr_en   = 1'b0;
  logic              rd        = 1'b0;
  logic [7:0]        command   = '0;
  logic [ADDR_W-1:0] address   = '0;
  logic [2:0]        nbytes    = '0;
  logic [DATA_W-1:0] data_in   = '0;
  logic              miso      = 1'b0;
`ifdef SPI_DUMMY_EN
  logic [3:0]        dummy_cycles = '0;
`endif
  logic              tready;
  logic              validflag_out;
  logic              sclk;
  logic              ss;
  logic              mosi;
  logic [DATA_W-1:0] data_out;

  int total = 0;
  int bad   = 0;

  // Flash-side observation: free-running counters, the bench works with deltas.
  int           rise_cnt   = 0;
  int           vf_cnt     = 0;
  int           ss_low     = 0;
  logic [127:0] mosi_sh    = '0;
  int           rise_base  = 0;
  int           vf_base    = 0;
  int           ss_base    = 0;
  logic [63:0]  resp_bits  = '0;
  int           resp_start = 0;

  spi_flash_master #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .validflag     (validflag),
    .tready        (tready),
    .command       (command),
    .address       (address),
    .addr_en       (addr_en),
    .rd            (rd),
    .nbytes        (nbytes),
    .data_in       (data_in),
`ifdef SPI_DUMMY_EN
    .dummy_cycles  (dummy_cycles),
`endif
    .data_out      (data_out),
    .validflag_out (validflag_out),
    .sclk          (sclk),
    .ss            (ss),
    .mosi          (mosi),
    .miso          (miso)
  );

  always #5 clk = ~clk;

  always @(posedge sclk) begin
    mosi_sh  = {mosi_sh[126:0], mosi};
    rise_cnt = rise_cnt + 1;
  end

  function automatic logic miso_bit(input int i);
    if (i >= resp_start && i < resp_start + 64)
      return resp_bits[63 - (i - resp_start)];
    return 1'b1;
  endfunction

  // Mode-0 slave: next bit is presented on ss fall and on every sclk fall.
  always @(negedge sclk or negedge ss) miso = miso_bit(rise_cnt - rise_base);

  always @(negedge clk) begin
    if (validflag_out) vf_cnt = vf_cnt + 1;
    if (!ss)           ss_low = ss_low + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic [7:0] c, input logic [ADDR_W-1:0] a, input logic ae,
                           input logic r, input logic [2:0] nb, input logic [DATA_W-1:0] d);
    @(posedge clk); #1;
    command   = c;
    address   = a;
    addr_en   = ae;
    rd        = r;
    nbytes    = nb;
    data_in   = d;
    validflag = 1'b1;
    rise_base = rise_cnt;
    vf_base   = vf_cnt;
    ss_base   = ss_low;
    @(posedge clk); #1;
    validflag = 1'b0;
    check("start_ss", ss, 1'b0);
    check("start_tready", tready, 1'b0);
    check("start_mosi", mosi, c[7]);
    // Scramble the request after accept; the captured copy must be used.
    command = ~c;
    address = ~a;
    addr_en = ~ae;
    rd      = ~r;
    nbytes  = ~nb;
    data_in = ~d;
  endtask

  task automatic wait_done(output int hold);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    hold = 0;
    while (!seen && n < 3000) begin
      @(negedge clk);
      n++;
      if (validflag_out) seen = 1'b1;
    end
    check("done_seen", seen, 1'b1);
    check("done_ss", ss, 1'b1);
    check("done_sclk", sclk, 1'b0);
    n = 0;
    while (!tready && n < 100) begin
      hold++;
      @(negedge clk);
      n++;
    end
    check("done_tready", tready, 1'b1);
  endtask

  initial begin
    int hold;
    int n;
    int vb;

    #12;
    check("rst_ss", ss, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_data_out", data_out, '0);
    check("rst_vf", validflag_out, 1'b0);
    check("rst_tready", tready, 1'b1);
    rst_n = 1'b1;

    // RDID, three-byte read without address
    resp_bits  = 64'hEF40180000000000;
    resp_start = 8;
    start_req(OP_RDID, '0, 1'b0, 1'b1, 3'd3, '0);
    wait_done(hold);
    check("rdid_pulses", 64'(rise_cnt - rise_base), 64'd32);
    check("rdid_mosi", mosi_sh[31:0], 64'h9F000000);
    check("rdid_data", data_out, 64'h00EF4018);
    check("rdid_vf", 64'(vf_cnt - vf_base), 64'd1);
    check("rdid_ss_low", 64'(ss_low - ss_base), 64'd130);

    // Page program with address and two write bytes; miso held high
    resp_bits  = '1;
    resp_start = 0;
    start_req(OP_PAGE_PROG, 24'h012345, 1'b1, 1'b0, 3'd2, 32'h0000ABCD);
    wait_done(hold);
    check("pp_pulses", 64'(rise_cnt - rise_base), 64'd48);
    check("pp_mosi", mosi_sh[47:0], 64'h02012345ABCD);
    check("pp_data_keep", data_out, 64'h00EF4018);
    check("pp_vf", 64'(vf_cnt - vf_base), 64'd1);

    // WREN, command only
    start_req(OP_WREN, '0, 1'b0, 1'b0, 3'd0, '0);
    wait_done(hold);
    check("wren_pulses", 64'(rise_cnt - rise_base), 64'd8);
    check("wren_mosi", mosi_sh[7:0], 64'h06);
    check("wren_vf", 64'(vf_cnt - vf_base), 64'd1);
    check("wren_hold", 64'(hold), 64'(CLK_DIV));
    check("wren_ss_low", 64'(ss_low - ss_base), 64'd34);

    // Request while busy must be dropped
    start_req(OP_WREN, '0, 1'b0, 1'b0, 3'd0, '0);
    repeat (6) @(posedge clk);
    #1;
    command   = OP_RDSR;
    rd        = 1'b1;
    addr_en   = 1'b0;
    nbytes    = 3'd1;
    validflag = 1'b1;
    @(posedge clk); #1;
    validflag = 1'b0;
    check("busy_tready", tready, 1'b0);
    wait_done(hold);
    repeat (30) @(negedge clk);
    check("busy_vf", 64'(vf_cnt - vf_base), 64'd1);
    check("busy_pulses", 64'(rise_cnt - rise_base), 64'd8);
    check("busy_mosi", mosi_sh[7:0], 64'h06);
    check("busy_ss_idle", ss, 1'b1);
    check("busy_data_keep", data_out, 64'h00EF4018);

    // READ with nbytes beyond DATA_W/8 saturates to four bytes
    resp_bits  = 64'hDEADBEEF00000000;
    resp_start = 32;
    start_req(OP_READ, 24'h000100, 1'b1, 1'b1, 3'd7, '0);
    wait_done(hold);
    check("sat_pulses", 64'(rise_cnt - rise_base), 64'd64);
    check("sat_mosi", mosi_sh[63:0], 64'h0300010000000000);
    check("sat_data", data_out, 64'hDEADBEEF);
    check("sat_vf", 64'(vf_cnt - vf_base), 64'd1);

    // Reset during the 10th address bit
    resp_bits  = '1;
    resp_start = 0;
    start_req(OP_PAGE_PROG, 24'h0ABCDE, 1'b1, 1'b0, 3'd4, 32'h11223344);
    n = 0;
    while ((rise_cnt - rise_base) < 18 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("mid_reached", 64'(rise_cnt - rise_base), 64'd18);
    check("mid_sclk_high", sclk, 1'b1);
    vb    = vf_cnt;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ss", ss, 1'b1);
    check("mid_rst_sclk", sclk, 1'b0);
    check("mid_rst_tready", tready, 1'b1);
    check("mid_rst_data", data_out, '0);
    #20;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("mid_no_vf", 64'(vf_cnt - vb), 64'd0);
    check("mid_tready", tready, 1'b1);
    check("mid_ss_idle", ss, 1'b1);

    resp_bits  = 64'hC220170000000000;
    resp_start = 8;
    start_req(OP_RDID, '0, 1'b0, 1'b1, 3'd3, '0);
    wait_done(hold);
    check("post_rdid_pulses", 64'(rise_cnt - rise_base), 64'd32);
    check("post_rdid_data", data_out, 64'h00C22017);
    check("post_rdid_vf", 64'(vf_cnt - vf_base), 64'd1);

`ifdef SPI_DUMMY_EN
    // FAST_READ with eight dummy cycles and one data byte
    resp_bits    = 64'h5A00000000000000;
    resp_start   = 40;
    dummy_cycles = 4'd8;
    start_req(OP_FAST_READ, 24'h000100, 1'b1, 1'b1, 3'd1, '0);
    dummy_cycles = 4'hF;
    wait_done(hold);
    dummy_cycles = 4'd0;
    check("fr_pulses", 64'(rise_cnt - rise_base), 64'd48);
    check("fr_mosi", mosi_sh[47:0], 64'h0B0001000000);
    check("fr_data", data_out, 64'h0000005A);
    check("fr_vf", 64'(vf_cnt - vf_base), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_flash_master.md
Name: spi_flash_master

Overview:
- Parametrised single-clock SPI master for serial NOR flash; successor to the fixed 8-bit-data / 24-bit-address flash master.
- Executes one framed transaction per request: 8-bit command, optional address, optional dummy cycles, then 0..DATA_W/8 data bytes written or read.
- Sits between the CPU-side controller and the flash pins. SPI mode 0 only. sclk is generated as a registered output, never used as a clock.

Parameters:
- DATA_W, 32, data word width in bits; multiple of 8, range 8..32.
- ADDR_W, 24, address width in bits; 24 or 32.
- CLK_DIV, 4, clk cycles per sclk period; even, >= 2; HALF = CLK_DIV/2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- validflag  in  1  request strobe; accepted when validflag && tready
- tready  out  1  high only in IDLE, ready to accept
- command  in  8  opcode
- address  in  ADDR_W  flash address
- addr_en  in  1  send address phase
- rd  in  1  1 = read data phase, 0 = write data phase
- nbytes  in  3  data byte count
- data_in  in  DATA_W  write data, right-aligned
- data_out  out  DATA_W  read data, right-aligned
- validflag_out  out  1  one-cycle completion pulse
- sclk  out  1  SPI clock, idles low
- ss  out  1  chip select, active low
- mosi  out  1  master out
- miso  in  1  master in

Behaviour:
- Reset values: ss=1, sclk=0, mosi=0, data_out=0, validflag_out=0, tready=1, FSM=IDLE. Reset asserted mid-transaction aborts immediately: ss=1, sclk=0, no validflag_out pulse.
- Request capture: all request inputs are registered on accept. Input changes after accept are ignored. validflag while tready=0 is dropped; there is no queue.
- FSM states: IDLE -> CMD -> ADDR (if addr_en) -> DUMMY (feature only) -> DATA (if nbytes != 0) -> SS_HOLD -> IDLE. Empty phases are skipped with zero cycles.
- nbytes > DATA_W/8 saturates to DATA_W/8.
- Timing after accept at edge k:
  - Edge k+1: ss=0, tready=0, mosi = command[7].
  - Each bit lasts CLK_DIV clk cycles: sclk low for HALF, then high for HALF.
  - miso is sampled on the clk edge where sclk rises.
  - mosi updates on the edge where sclk falls.
- Bit order: MSB first in every phase. Command is 8 bits; address is ADDR_W bits.
- Write data: the low nbytes bytes of data_in are sent, most significant of those first (e.g. 0x0000ABCD with nbytes=2 sends 0xAB then 0xCD). miso is ignored.
- Read data: mosi=0 during the data phase. Received bytes are shifted in right-aligned; unreceived upper bytes are 0.
- Completion: after the final sclk falling edge, sclk stays low and ss rises HALF cycles later. In that same cycle validflag_out=1 for exactly one cycle and data_out is updated. data_out is updated on reads only and holds until the next read completes.
- SS_HOLD: ss stays high for CLK_DIV cycles, then tready=1. This guarantees a minimum ss-high time between back-to-back transactions.
- Total sclk pulses = 8 + (addr_en ? ADDR_W : 0) + dummy + 8 * nbytes_sat.

Optional Feature:
- Macro: SPI_DUMMY_EN.
- Defined:
  - Adds input dummy_cycles [3:0], captured on accept.
  - Adds DUMMY state after ADDR: dummy_cycles sclk pulses with mosi=0 and miso ignored.
  - dummy_cycles=0 skips the state.
- Undefined: no port, no DUMMY state; behaviour is identical to dummy_cycles=0.

Decomposition:
- Package spi_pkg:
  - FSM state enumeration.
  - SPI_COM_W=8.
  - Opcode constants: READ 0x03, FAST_READ 0x0B, PAGE_PROG 0x02, WREN 0x06, RDSR 0x05, RDID 0x9F.
  - Bit-counter width function.
- Sub-module spi_sclk_gen:
  - Divide counter, sclk register, rise/fall strobes.
  - Enabled by the FSM.
  - Restarts with sclk low on enable assertion.

Test Plan (CLK_DIV=4 unless stated):
1. RDID: command=0x9F, addr_en=0, rd=1, nbytes=3; flash model returns EF 40 18 → mosi 10011111, 32 sclk pulses, data_out=0x00EF4018, one validflag_out pulse, ss low for exactly 128+2 clk cycles.
2. Page program: command=0x02, address=0x012345, addr_en=1, rd=0, nbytes=2, data_in=0x0000ABCD → mosi stream 02 01 23 45 AB CD MSB-first, 48 pulses, data_out unchanged.
3. WREN: command=0x06, addr_en=0, nbytes=0 → 8 sclk pulses, validflag_out pulses, tready returns exactly CLK_DIV cycles after ss rises.
4. Reset mid-transaction: rst_n low during the 10th address bit → ss=1 and sclk=0 asynchronously, no validflag_out; after release tready=1 and a new RDID completes correctly.
5. Busy handling and saturation:
   - validflag pulsed while tready=0 → ignored, exactly one transaction completes.
   - Read with nbytes=7, DATA_W=32 → 4 bytes read (32 data pulses).
6. SPI_DUMMY_EN: FAST_READ 0x0B, address 0x000100, dummy_cycles=8, nbytes=1 → 8+24+8+8=48 pulses, data_out = the byte driven during the last 8 pulses.
